// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helper for the show-ahead fifo.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int PTR_MAX_W      = 16;

  // Increment modulo 2^aw; callers truncate the result to their pointer width.
  function automatic logic [PTR_MAX_W-1:0] ptr_next(input logic [PTR_MAX_W-1:0] p,
                                                    input int unsigned aw);
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(1) << aw) - PTR_MAX_W'(1);
    return (p + PTR_MAX_W'(1)) & mask;
  endfunction
endpackage

// File: rtl/fifo_if.sv
// Push/pop bus of the fifo; count travels on it only when FIFO_COUNT_EN is defined.
interface fifo_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  rd;
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] r_data;
`ifdef FIFO_COUNT_EN
  logic [ADDR_WIDTH:0]   count;
`endif

  modport master (
    output rd, wr, w_data,
    input  empty, full, r_data
`ifdef FIFO_COUNT_EN
    , input count
`endif
  );

  modport slave (
    input  rd, wr, w_data,
    output empty, full, r_data
`ifdef FIFO_COUNT_EN
    , output count
`endif
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointers, registered empty/full flags and qualified push/pop; flags update on the same edge.
// Pushes while full without a pop are dropped, pops while empty are dropped; FIFO_COUNT_EN adds count.
module fifo_ctrl import fifo_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  output logic                  we,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] wp,
  output logic [ADDR_WIDTH-1:0] rp,
  output logic                  empty,
`ifdef FIFO_COUNT_EN
  output logic [ADDR_WIDTH:0]   count,
`endif
  output logic                  full
);
  logic [ADDR_WIDTH-1:0] wp_nxt;
  logic [ADDR_WIDTH-1:0] rp_nxt;

  // A pop frees the head slot on the same edge, so a full fifo still accepts wr with rd.
  assign we     = wr & (~full | rd);
  assign re     = rd & ~empty;
  assign wp_nxt = ADDR_WIDTH'(ptr_next(PTR_MAX_W'(wp), ADDR_WIDTH));
  assign rp_nxt = ADDR_WIDTH'(ptr_next(PTR_MAX_W'(rp), ADDR_WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      case ({we, re})
        2'b10: begin
          wp    <= wp_nxt;
          empty <= 1'b0;
          full  <= (wp_nxt == rp);
        end
        2'b01: begin
          rp    <= rp_nxt;
          full  <= 1'b0;
          empty <= (rp_nxt == wp);
        end
        2'b11: begin
          wp <= wp_nxt;
          rp <= rp_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (we && !re) begin
      count <= count + 1'b1;
    end else if (re && !we) begin
      count <= count - 1'b1;
    end
  end
`endif
endmodule

// File: rtl/fifo.sv
// Single-clock show-ahead fifo, 1-cycle write-to-read, r_data is the head (0 when empty).
// Full drops lone writes, empty drops reads; FIFO_COUNT_EN adds the occupancy output.
module fifo import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic  clk,
  input  logic  reset,
  fifo_if.slave bus
);
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic                  empty;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .rd    (bus.rd),
    .wr    (bus.wr),
    .we    (we),
    .re    (re),
    .wp    (wp),
    .rp    (rp),
    .empty (empty),
`ifdef FIFO_COUNT_EN
    .count (bus.count),
`endif
    .full  (bus.full)
  );

  // Storage is deliberately not reset; stale words sit behind empty and are never shown.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wp] <= bus.w_data;
    end
  end

  assign bus.empty  = empty;
  assign bus.r_data = empty ? '0 : mem[rp];
endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo with hand-computed expectations at default parameters.
module tb_fifo;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fifo_if #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) bus ();

  fifo #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input int d);
    bus.rd     = r;
    bus.wr     = w;
    bus.w_data = 24'(d);
    @(posedge clk);
    #1;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic fill_1_to_8();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, i);
      check("fill_rdata", 32'(bus.r_data), 32'd1);
      check("fill_full", 32'(bus.full), 32'(i == 8));
      check("fill_empty", 32'(bus.empty), 32'd0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.w_data = '0;
    reset      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_rdata", 32'(bus.r_data), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    fill_1_to_8();
`ifdef FIFO_COUNT_EN
    check("fill_count", 32'(bus.count), 32'd8);
`endif

    // Overflow: lone write while full is ignored.
    cyc(1'b0, 1'b1, 99);
    check("ovf_full", 32'(bus.full), 32'd1);
    check("ovf_rdata", 32'(bus.r_data), 32'd1);
`ifdef FIFO_COUNT_EN
    check("ovf_count", 32'(bus.count), 32'd8);
`endif
    for (int i = 1; i <= 8; i++) begin
      check("drain_rdata", 32'(bus.r_data), 32'(i));
      cyc(1'b1, 1'b0, 0);
      check("drain_full", 32'(bus.full), 32'd0);
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_rdata0", 32'(bus.r_data), 32'd0);

    // Streaming: simultaneous pop/push while full.
    fill_1_to_8();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 9 + k);
      check("stream_rdata", 32'(bus.r_data), 32'(2 + k));
      check("stream_full", 32'(bus.full), 32'd1);
`ifdef FIFO_COUNT_EN
      check("stream_count", 32'(bus.count), 32'd8);
`endif
    end
    for (int i = 4; i <= 11; i++) begin
      check("sdrain_rdata", 32'(bus.r_data), 32'(i));
      cyc(1'b1, 1'b0, 0);
    end
    check("sdrain_empty", 32'(bus.empty), 32'd1);

    // Underflow, then rd&wr while empty behaves as a write only.
    cyc(1'b1, 1'b0, 0);
    check("udf_empty", 32'(bus.empty), 32'd1);
    check("udf_rdata", 32'(bus.r_data), 32'd0);
    cyc(1'b1, 1'b1, 5);
    check("udf_rw_empty", 32'(bus.empty), 32'd0);
    check("udf_rw_rdata", 32'(bus.r_data), 32'd5);
    check("udf_rw_full", 32'(bus.full), 32'd0);
`ifdef FIFO_COUNT_EN
    check("udf_rw_count", 32'(bus.count), 32'd1);
`endif
    cyc(1'b1, 1'b0, 0);
    check("udf_pop_empty", 32'(bus.empty), 32'd1);

    // Wrap: alternating single push and pop walks both pointers around.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 100 + i);
      check("wrap_rdata", 32'(bus.r_data), 32'(100 + i));
      check("wrap_nempty", 32'(bus.empty), 32'd0);
      cyc(1'b1, 1'b0, 0);
      check("wrap_empty", 32'(bus.empty), 32'd1);
    end

    // Asynchronous reset between edges with the fifo full.
    fill_1_to_8();
    #2;
    reset = 1'b1;
    #1;
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_full", 32'(bus.full), 32'd0);
    check("arst_rdata", 32'(bus.r_data), 32'd0);
`ifdef FIFO_COUNT_EN
    check("arst_count", 32'(bus.count), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b1, 42);
    check("post_rst_rdata", 32'(bus.r_data), 32'd42);
    cyc(1'b1, 1'b0, 0);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
